// File: rtl/reg_file_bank_if.sv
// Bus bundle for reg_file_bank: one write port, two read ports, clear request and busy flag.
interface reg_file_bank_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [WIDTH-1:0]  rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_b;
  logic              clear;
  logic              busy;

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, clear,
    output rd_data_a, rd_data_b, busy
  );

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, clear,
    input  rd_data_a, rd_data_b, busy
  );
endinterface

// File: rtl/reg_file_bank.sv
// Register file, 1 write / 2 registered read ports, with a DEPTH-edge zeroing sweep on clear/reset.
// Optional macro REG_FILE_BANK_BYPASS_EN forwards same-edge write data to matching read ports.
module reg_file_bank #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic           clk,
  input  logic           reset,
  reg_file_bank_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  logic [WIDTH-1:0]  mem [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  rd_a_q, rd_a_d;
  logic [WIDTH-1:0]  rd_b_q, rd_b_d;

  logic              wr_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  assign wr_ok = (state_q == IDLE) && bus.wr_en && !bus.clear;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    busy_d    = busy_q;
    rd_a_d    = mem[bus.rd_addr_a];
    rd_b_d    = mem[bus.rd_addr_b];
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    if (state_q == SWEEP) begin
      rd_a_d    = '0;
      rd_b_d    = '0;
      mem_waddr = idx_q;
      mem_wdata = '0;
      idx_d     = idx_q + 1'b1;
      // The last address ends the sweep; the index is not allowed to wrap into a second pass.
      if (idx_q == ADDR_W'(DEPTH - 1)) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        idx_d   = '0;
      end
    end else begin
`ifdef REG_FILE_BANK_BYPASS_EN
      if (wr_ok && (bus.rd_addr_a == bus.wr_addr)) rd_a_d = bus.wr_data;
      if (wr_ok && (bus.rd_addr_b == bus.wr_addr)) rd_b_d = bus.wr_data;
`else
`endif
      if (bus.clear) begin
        state_d = SWEEP;
        busy_d  = 1'b1;
        idx_d   = '0;
      end
    end
  end

  // Gating on reset keeps a write coinciding with reset assertion from landing.
  assign mem_we = !reset && ((state_q == SWEEP) || wr_ok);

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SWEEP;
      idx_q   <= '0;
      busy_q  <= 1'b1;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
    end
  end

  assign bus.rd_data_a = rd_a_q;
  assign bus.rd_data_b = rd_b_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_reg_file_bank.sv
// Self-checking bench for reg_file_bank: vector table plus sweep/reset sequences, scoreboard-checked.
module tb_reg_file_bank;

`ifdef REG_FILE_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset;
  reg_file_bank_if #(.WIDTH(16), .ADDR_W(4)) bus ();

  reg_file_bank #(.WIDTH(16), .ADDR_W(4), .DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
  } exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        clr;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        ebusy;
  } vec_t;

  exp_t        sb_q[$];
  vec_t        tbl[12];
  int          total = 0;
  int          bad   = 0;

  logic [15:0] m_mem [16];
  bit          m_sweep;
  int          m_idx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic set_in(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                        input logic [3:0] ra, input logic [3:0] rb, input logic clr);
    bus.wr_en     = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.rd_addr_a = ra;
    bus.rd_addr_b = rb;
    bus.clear     = clr;
  endtask

  // Behavioural reference: one rising edge given the inputs currently on the bus.
  task automatic model_step(output exp_t e);
    bit fa, fb;
    if (m_sweep) begin
      e.a = 16'h0;
      e.b = 16'h0;
      m_mem[m_idx] = 16'h0;
      if (m_idx == 15) m_sweep = 1'b0;
      else m_idx++;
    end else begin
      fa = BYP && bus.wr_en && !bus.clear && (bus.rd_addr_a == bus.wr_addr);
      fb = BYP && bus.wr_en && !bus.clear && (bus.rd_addr_b == bus.wr_addr);
      e.a = fa ? bus.wr_data : m_mem[bus.rd_addr_a];
      e.b = fb ? bus.wr_data : m_mem[bus.rd_addr_b];
      if (bus.clear) begin
        m_sweep = 1'b1;
        m_idx   = 0;
      end else if (bus.wr_en) begin
        m_mem[bus.wr_addr] = bus.wr_data;
      end
    end
    e.busy = m_sweep;
  endtask

  task automatic cycle(input string nm, input bit use_tbl, input exp_t te);
    exp_t e, got;
    model_step(e);
    if (use_tbl) e = te;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      chk({nm, "_a"},    {16'h0, bus.rd_data_a}, {16'h0, got.a});
      chk({nm, "_b"},    {16'h0, bus.rd_data_b}, {16'h0, got.b});
      chk({nm, "_busy"}, {31'h0, bus.busy},      {31'h0, got.busy});
    end
  endtask

  task automatic step(input string nm);
    exp_t none;
    none = '{16'h0, 16'h0, 1'b0};
    cycle(nm, 1'b0, none);
  endtask

  // Called at posedge+1; asserts reset between edges and checks its immediate effect.
  task automatic async_reset(input string nm, input int hold);
    set_in(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk({nm, "_imm_a"},    {16'h0, bus.rd_data_a}, 32'h0);
    chk({nm, "_imm_b"},    {16'h0, bus.rd_data_b}, 32'h0);
    chk({nm, "_imm_busy"}, {31'h0, bus.busy},      32'h1);
    repeat (hold) @(posedge clk);
    #1;
    chk({nm, "_hold_busy"}, {31'h0, bus.busy}, 32'h1);
    #3;
    reset   = 1'b0;
    m_sweep = 1'b1;
    m_idx   = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    set_in(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0);
    do begin
      step(nm);
      n++;
    end while (bus.busy === 1'b1 && n < 40);
    chk({nm, "_edges"}, n, 32'd16);
  endtask

  initial begin
    exp_t te;
    int   fall_at;

    for (int i = 0; i < 16; i++) m_mem[i] = 'x;
    m_sweep = 1'b1;
    m_idx   = 0;
    set_in(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0);

    tbl[0]  = '{1'b1, 4'd3,  16'hA5A5, 4'd0,  4'd0,  1'b0, 16'h0000, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 4'd12, 16'h1234, 4'd3,  4'd3,  1'b0, 16'hA5A5, 16'hA5A5, 1'b0};
    tbl[2]  = '{1'b0, 4'd0,  16'h0000, 4'd3,  4'd12, 1'b0, 16'hA5A5, 16'h1234, 1'b0};
    tbl[3]  = '{1'b1, 4'd5,  16'h0001, 4'd5,  4'd5,  1'b0,
                BYP ? 16'h0001 : 16'h0000, BYP ? 16'h0001 : 16'h0000, 1'b0};
    tbl[4]  = '{1'b1, 4'd5,  16'hBEEF, 4'd5,  4'd12, 1'b0,
                BYP ? 16'hBEEF : 16'h0001, 16'h1234, 1'b0};
    tbl[5]  = '{1'b0, 4'd0,  16'h0000, 4'd5,  4'd5,  1'b0, 16'hBEEF, 16'hBEEF, 1'b0};
    tbl[6]  = '{1'b1, 4'd9,  16'h0F0F, 4'd12, 4'd9,  1'b0,
                16'h1234, BYP ? 16'h0F0F : 16'h0000, 1'b0};
    tbl[7]  = '{1'b0, 4'd0,  16'h0000, 4'd9,  4'd3,  1'b0, 16'h0F0F, 16'hA5A5, 1'b0};
    tbl[8]  = '{1'b1, 4'd0,  16'hFFFF, 4'd15, 4'd0,  1'b0,
                16'h0000, BYP ? 16'hFFFF : 16'h0000, 1'b0};
    tbl[9]  = '{1'b1, 4'd15, 16'h8001, 4'd0,  4'd15, 1'b0,
                16'hFFFF, BYP ? 16'h8001 : 16'h0000, 1'b0};
    tbl[10] = '{1'b0, 4'd0,  16'h0000, 4'd15, 4'd15, 1'b0, 16'h8001, 16'h8001, 1'b0};
    tbl[11] = '{1'b1, 4'd2,  16'h5555, 4'd2,  4'd3,  1'b1, 16'h0000, 16'hA5A5, 1'b1};

    // Power-on reset and the initial zeroing sweep
    reset = 1'b1;
    #1;
    chk("por_a",    {16'h0, bus.rd_data_a}, 32'h0);
    chk("por_b",    {16'h0, bus.rd_data_b}, 32'h0);
    chk("por_busy", {31'h0, bus.busy},      32'h1);
    repeat (2) @(posedge clk);
    #4;
    reset = 1'b0;
    wait_idle("por_sweep");
    for (int i = 0; i < 16; i++) begin
      set_in(1'b0, 4'd0, 16'h0, 4'(i), 4'(15 - i), 1'b0);
      step("zero_read");
    end

    // Vector table: writes, dual reads, forwarding cases, clear+write collision
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb, tbl[i].clr);
      te = '{tbl[i].ea, tbl[i].eb, tbl[i].ebusy};
      cycle($sformatf("vec%0d", i), 1'b1, te);
    end

    // Sweep in progress: dropped write to 7, ignored clear at sweep edge 8
    fall_at = -1;
    for (int i = 0; i < 16; i++) begin
      set_in(i == 2, 4'd7, 16'hFFFF, 4'd7, 4'd12, i == 7);
      step("sweep");
      if (bus.busy === 1'b0 && fall_at < 0) fall_at = i + 1;
    end
    chk("clear_sweep_len", fall_at, 32'd16);
    set_in(1'b0, 4'd0, 16'h0, 4'd7, 4'd2, 1'b0);
    step("post_sweep_7_2");
    set_in(1'b0, 4'd0, 16'h0, 4'd12, 4'd3, 1'b0);
    step("post_sweep_12_3");

    // Reset from IDLE with non-zero read data
    set_in(1'b1, 4'd4, 16'h1357, 4'd0, 4'd0, 1'b0);
    step("wr4");
    set_in(1'b0, 4'd0, 16'h0, 4'd4, 4'd4, 1'b0);
    step("rd4");
    async_reset("idle_rst", 2);
    wait_idle("idle_rst_sweep");

    // Reset mid-sweep at sweep edge 10
    set_in(1'b1, 4'd8, 16'h2468, 4'd0, 4'd0, 1'b0);
    step("wr8");
    set_in(1'b0, 4'd0, 16'h0, 4'd8, 4'd8, 1'b1);
    step("clr2");
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, 4'd0, 16'h0, 4'd8, 4'd4, 1'b0);
      step("sweep10");
    end
    async_reset("mid_rst", 2);
    wait_idle("mid_rst_sweep");
    set_in(1'b0, 4'd0, 16'h0, 4'd8, 4'd2, 1'b0);
    step("post_rst_8_2");

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_bank.md
REG_FILE_BANK -- requirements
Module: reg_file_bank

Interface
REQ-001 Parameter WIDTH, default 16, data width of each register in bits.
REQ-002 Parameter ADDR_W, default 4, address width in bits.
REQ-003 Parameter DEPTH, default 16, number of registers; DEPTH SHALL equal 2**ADDR_W.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  write request for wr_addr/wr_data this cycle.
REQ-007 wr_addr  input  ADDR_W  write address.
REQ-008 wr_data  input  WIDTH  write data.
REQ-009 rd_addr_a  input  ADDR_W  read port A address.
REQ-010 rd_data_a  output  WIDTH  read port A data, registered.
REQ-011 rd_addr_b  input  ADDR_W  read port B address.
REQ-012 rd_data_b  output  WIDTH  read port B data, registered.
REQ-013 clear  input  1  single-cycle request to zero all registers.
REQ-014 busy  output  1  high while a clear sweep is in progress.

Function
REQ-015 Block SHALL hold DEPTH registers of WIDTH bits with one write port and two independent read ports.
REQ-016 Write: when wr_en=1 and busy=0, register[wr_addr] SHALL take wr_data at the rising edge.
REQ-017 Read latency SHALL be one cycle: rd_data_x after edge N equals register[rd_addr_x] sampled at edge N.
REQ-018 Both read ports MAY address the same register; both SHALL return identical data.
REQ-019 Controller SHALL have two states: IDLE (busy=0) and SWEEP (busy=1).
REQ-020 IDLE->SWEEP on a rising edge with clear=1; sweep index SHALL be set to 0.
REQ-021 In SWEEP, each edge SHALL write zero to register[index] and increment index; edge writing address DEPTH-1 SHALL return to IDLE; sweep takes exactly DEPTH edges.
REQ-022 Index SHALL be ADDR_W bits and SHALL NOT wrap to restart a sweep.
REQ-023 In SWEEP, wr_en SHALL be ignored (write dropped, no later retry) and rd_data_a/rd_data_b SHALL load zero.
REQ-024 clear asserted while in SWEEP SHALL be ignored; sweep SHALL NOT restart.
REQ-025 clear and wr_en both high in IDLE on the same edge: write SHALL be dropped, SWEEP entered.
REQ-026 Simultaneous write and read of the same address in IDLE: behaviour per REQ-033/REQ-034.

Reset
REQ-027 Asserting reset SHALL immediately force state SWEEP, index 0, busy=1, rd_data_a=0, rd_data_b=0, independent of clk.
REQ-028 Register contents SHALL NOT be reset directly; zeroing SHALL occur via the sweep starting on the first rising edge after reset deasserts.
REQ-029 Reset asserted mid-sweep SHALL restart the sweep from index 0 after deassertion.
REQ-030 After reset deassertion, busy SHALL fall after exactly DEPTH rising edges; all registers read 0 thereafter.
REQ-031 Reset asserted during a write edge: the write SHALL NOT occur.

Configuration
REQ-032 Macro REG_FILE_BANK_BYPASS_EN selects write-to-read forwarding.
REQ-033 Defined: in IDLE, if wr_en=1 and rd_addr_x==wr_addr at edge N, rd_data_x after edge N SHALL equal wr_data (per port, independently).
REQ-034 Undefined: same case SHALL return the register's previous value; new value is visible from edge N+1.
REQ-035 Macro SHALL NOT affect SWEEP behaviour, reset, or latency.

Verification (WIDTH=16, DEPTH=16)
REQ-036 Reset pulse, then 16 edges with no stimulus -> busy=1 for exactly 16 edges then 0; reads of addresses 0..15 return 16'h0000.
REQ-037 Write 16'hA5A5 to addr 3, 16'h1234 to addr 12; read A=3, B=12 -> 16'hA5A5 and 16'h1234 one cycle later.
REQ-038 wr_en=1, wr_addr=5, wr_data=16'hBEEF, rd_addr_a=5, register[5]=16'h0001 -> rd_data_a=16'hBEEF with macro, 16'h0001 without; 16'hBEEF next cycle in both.
REQ-039 Pulse clear with registers non-zero; write 16'hFFFF to addr 7 during sweep; pulse clear again at sweep edge 8 -> busy exactly 16 cycles, rd_data=0 during sweep, addr 7 reads 0 afterwards.
REQ-040 Assert reset asynchronously at sweep edge 10 for 2 cycles -> busy stays 1, rd_data=0 immediately, fresh 16-edge sweep after release.
REQ-041 clear and wr_en (addr 2, 16'h5555) on same IDLE edge -> SWEEP entered, addr 2 reads 0 after sweep.
